// File: rtl/adg715_pkg.sv
// Shared types and constants for the ADG715 I2C write master.
package adg715_pkg;

  typedef enum logic [3:0] {
    S_RSTHOLD,
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK1,
    S_DATA,
    S_ACK2,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [4:0] ADG715_PREFIX  = 5'b10010;
  localparam int         QTR_CYCLES_DEF = 63;
  localparam int         RST_HOLD_DEF   = 100;

  function automatic logic [7:0] addr_byte(input logic [1:0] a);
    return {ADG715_PREFIX, a, 1'b0};
  endfunction

  function automatic logic [7:0] switch_byte(input logic [2:0] ch);
    return 8'h01 << ch;
  endfunction

endpackage

// File: rtl/adg715_i2c_writer_qtr_tick.sv
// SCL quarter-period divider: one-cycle tick at every quarter boundary plus
// the 2-bit quarter index within the current bit-time.
module i2c_qtr_tick #(
  parameter int QTR_CYCLES = 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic       tick,
  output logic [1:0] qtr
);

  localparam int CW = $clog2(QTR_CYCLES);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(QTR_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      qtr <= 2'd0;
    end else if (clr) begin
      cnt <= '0;
      qtr <= 2'd0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        qtr <= qtr + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adg715_i2c_writer.sv
// I2C write master for ADG715 switches: one address+switch byte write per
// accepted request, plus the switches' post-reset hold on RESET_ASW.
module adg715_i2c_writer
  import adg715_pkg::*;
#(
  parameter int QTR_CYCLES = QTR_CYCLES_DEF,
  parameter int RST_HOLD   = RST_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       startflag,
  input  logic [1:0] ASW_Addr,
  input  logic [2:0] ASW_Channel,
  input  logic       SDA_ASW_i,
  output logic       SDA_ASW_oe,
  output logic       SCL_ASW,
  output logic       RESET_ASW,
  output logic       busy,
  output logic       Stopflag,
  output logic       nack
);

  localparam int RCW = $clog2(RST_HOLD + 1);

  state_t         state, state_nx;
  logic [1:0]     addr_q;
  logic [2:0]     ch_q;
  logic [2:0]     bit_idx;
  logic           nack_r;
  logic           sda_meta, sda_sync;
  logic [RCW-1:0] rst_cnt;
  logic [7:0]     tx_byte;
  logic           tick, accept, active, bit_end;
  logic [1:0]     qtr;

  assign accept  = (state == S_IDLE) && startflag;
  assign active  = (state inside {S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP});
  assign bit_end = tick && (qtr == 2'd3);

  assign busy      = (state != S_IDLE);
  assign RESET_ASW = (state != S_RSTHOLD);
  assign Stopflag  = (state == S_DONE);
  assign nack      = (state == S_DONE) && nack_r;

  i2c_qtr_tick #(.QTR_CYCLES(QTR_CYCLES)) u_qtr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (active),
    .tick    (tick),
    .qtr     (qtr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RSTHOLD;
      addr_q   <= 2'd0;
      ch_q     <= 3'd0;
      bit_idx  <= 3'd7;
      nack_r   <= 1'b0;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      rst_cnt  <= '0;
    end else begin
      state    <= state_nx;
      sda_meta <= SDA_ASW_i;
      sda_sync <= sda_meta;
      if (state == S_RSTHOLD) rst_cnt <= rst_cnt + 1'b1;
      if (accept) begin
        addr_q  <= ASW_Addr;
        ch_q    <= ASW_Channel;
        nack_r  <= 1'b0;
        bit_idx <= 3'd7;
      end
      // bit_idx wraps 0 -> 7 at the end of ADDR, ready for DATA
      if ((state == S_ADDR || state == S_DATA) && bit_end) bit_idx <= bit_idx - 3'd1;
      if ((state == S_ACK1 || state == S_ACK2) && tick && qtr == 2'd2 && sda_sync)
        nack_r <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RSTHOLD: if (rst_cnt == RCW'(RST_HOLD - 1)) state_nx = S_IDLE;
      S_IDLE:    if (startflag) state_nx = S_START;
      S_START:   if (bit_end) state_nx = S_ADDR;
      S_ADDR:    if (bit_end && bit_idx == 3'd0) state_nx = S_ACK1;
      S_ACK1:    if (bit_end) state_nx = S_DATA;
      S_DATA:    if (bit_end && bit_idx == 3'd0) state_nx = S_ACK2;
      S_ACK2:    if (bit_end) state_nx = S_STOP;
      S_STOP:    if (bit_end) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Bus drive: SCL high in q1-q2 of data/ACK bits; SDA only changes with SCL low
  always_comb begin
    tx_byte    = (state == S_DATA) ? switch_byte(ch_q) : addr_byte(addr_q);
    SCL_ASW    = 1'b1;
    SDA_ASW_oe = 1'b0;
    case (state)
      S_START: SDA_ASW_oe = qtr[1];
      S_ADDR, S_DATA: begin
        SCL_ASW    = qtr[1] ^ qtr[0];
        SDA_ASW_oe = ~tx_byte[bit_idx];
      end
      S_ACK1, S_ACK2: SCL_ASW = qtr[1] ^ qtr[0];
      S_STOP: begin
        SCL_ASW    = (qtr != 2'd0);
        SDA_ASW_oe = ~qtr[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adg715_i2c_writer.sv
// Scoreboard bench: an I2C bus decoder/slave rebuilds the bytes from SCL/SDA,
// and each Stopflag is matched against the request model's expectations.
module tb_adg715_i2c_writer;

  localparam int Q   = 63;
  localparam int RH  = 100;
  localparam int TXN = 80 * Q;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       startflag = 1'b0;
  logic [1:0] ASW_Addr = 2'd0;
  logic [2:0] ASW_Channel = 3'd0;
  logic       SDA_ASW_i, SDA_ASW_oe, SCL_ASW, RESET_ASW, busy, Stopflag, nack;
  logic       slave_low = 1'b0;
  logic       sda_line;

  assign sda_line  = !(SDA_ASW_oe || slave_low);
  assign SDA_ASW_i = sda_line;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adg715_i2c_writer #(.QTR_CYCLES(Q), .RST_HOLD(RH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .startflag   (startflag),
    .ASW_Addr    (ASW_Addr),
    .ASW_Channel (ASW_Channel),
    .SDA_ASW_i   (SDA_ASW_i),
    .SDA_ASW_oe  (SDA_ASW_oe),
    .SCL_ASW     (SCL_ASW),
    .RESET_ASW   (RESET_ASW),
    .busy        (busy),
    .Stopflag    (Stopflag),
    .nack        (nack)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic        nk;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0, n_stop = 0, n_exp = 0;
  int unsigned ref_free_at = 0;
  bit          ack1_en = 1'b1, ack2_en = 1'b1;
  logic [7:0]  dec_a = 8'h00, dec_d = 8'h00;
  bit          start_seen = 1'b0, stop_seen = 1'b0;
  int          nbits = 0;
  bit          pscl = 1'b1, psda = 1'b1, scl_s, sda_s;
  bit          pend_busy = 1'b0;
  exp_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bus decoder and ACKing slave, working only from SCL/SDA line levels
  initial begin : bus
    forever begin
      @(posedge clk); #1;
      scl_s = SCL_ASW;
      sda_s = sda_line;
      if (!reset_n) slave_low = 1'b0;
      else if (pscl && scl_s && psda && !sda_s) begin
        start_seen = 1'b1; stop_seen = 1'b0; nbits = 0; dec_a = 8'h00; dec_d = 8'h00;
      end else if (pscl && scl_s && !psda && sda_s) stop_seen = 1'b1;
      else if (!pscl && scl_s) begin
        if (nbits < 8) dec_a = {dec_a[6:0], sda_s};
        else if (nbits >= 9 && nbits < 17) dec_d = {dec_d[6:0], sda_s};
        nbits++;
      end else if (pscl && !scl_s)
        slave_low = (nbits == 8 && ack1_en) || (nbits == 17 && ack2_en);
      pscl = scl_s;
      psda = sda_s;
    end
  end

  initial begin : mon
    forever begin
      @(posedge clk); #1;
      if (pend_busy) begin
        chk("busy_after_stop", busy, 0);
        pend_busy = 1'b0;
      end
      if (reset_n && Stopflag) begin
        n_stop++;
        if (sb.size() == 0) chk("unexpected_stop", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("addr_byte", dec_a, mon_e.a);
          chk("data_byte", dec_d, mon_e.d);
          chk("start_cond", start_seen, 1);
          chk("stop_cond", stop_seen, 1);
          chk("nack", nack, mon_e.nk);
          chk("stop_latency", cyc - mon_e.acc, TXN);
          chk("busy_at_stop", busy, 1);
          start_seen = 1'b0;
          stop_seen  = 1'b0;
          pend_busy  = 1'b1;
        end
      end
    end
  end

  // Request model: accepted iff sampled at or after the first free edge
  task automatic req(input logic [1:0] a, input logic [2:0] ch, input bit k1, input bit k2,
                     input int unsigned lead);
    int unsigned e;
    exp_t x;
    @(negedge clk);
    while (cyc + 1 + lead < ref_free_at) @(negedge clk);
    startflag = 1'b1; ASW_Addr = a; ASW_Channel = ch;
    e = cyc + 1;
    if (e >= ref_free_at) begin
      x.a   = 8'(144 + 2 * a);
      x.d   = 8'(1 << ch);
      x.nk  = !(k1 && k2);
      x.acc = e;
      sb.push_back(x);
      n_exp++;
      ref_free_at = e + TXN + 2;
      ack1_en = k1;
      ack2_en = k2;
    end
    @(negedge clk);
    startflag = 1'b0;
    ASW_Addr = 2'($urandom);
    ASW_Channel = 3'($urandom);
  endtask

  task automatic do_reset(input int hold_low);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_scl", SCL_ASW, 1);
    chk("rst_sda_oe", SDA_ASW_oe, 0);
    chk("rst_reset_asw", RESET_ASW, 0);
    chk("rst_busy", busy, 1);
    chk("rst_stopflag", Stopflag, 0);
    chk("rst_nack", nack, 0);
    n_exp -= sb.size();
    sb.delete();
    repeat (hold_low) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= RH; k++) begin
      @(posedge clk); #1;
      if (k == RH - 1) begin
        chk("reset_asw_hold", RESET_ASW, 0);
        chk("busy_hold", busy, 1);
      end
    end
    chk("reset_asw_release", RESET_ASW, 1);
    chk("busy_release", busy, 0);
    ref_free_at = cyc + 1;
  endtask

  initial begin : stim
    int t;
    do_reset(5);
    chk("idle_scl", SCL_ASW, 1);
    chk("idle_sda_oe", SDA_ASW_oe, 0);
    req(2'd2, 3'd5, 1, 1, 0);
    req(2'd0, 3'd0, 1, 1, 0);
    req(2'd3, 3'd7, 1, 1, 0);
    req(2'd1, 3'd3, 1, 0, 0);
    req(2'd1, 3'd4, 1, 1, 0);
    // one real request, then pulses mid-DATA and on the Stopflag cycle
    req(2'd2, 3'd6, 1, 1, 0);
    req(2'd0, 3'd1, 1, 1, 32 * Q);
    req(2'd3, 3'd2, 1, 1, 1);
    repeat (3) req(2'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0, 0);
    // abort in ADDR, then recover
    req(2'd1, 3'd2, 1, 1, 0);
    repeat (3 * 4 * Q) @(posedge clk);
    do_reset(3);
    req(2'd2, 3'd1, 1, 1, 0);
    t = 0;
    while (sb.size() != 0 && t < 3 * TXN) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    chk("pending_expected", sb.size(), 0);
    chk("stop_count", n_stop, n_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adg715_i2c_writer.md
# adg715_i2c_writer

I2C write master for the ADG715 octal analog switches in the receive-filter path. It sits directly downstream of the filter-band selector. On each start request it sends one two-byte write: the device address, then a one-hot switch byte derived from the requested channel. It also drives the switches' active-low reset line and reports completion with a one-cycle `Stopflag`.

## Interface
- `QTR_CYCLES`, default 63: clk cycles per SCL quarter-period. 4×63 = 252 cycles gives 396.8 kHz at 100 MHz. Legal range ≥ 2.
- `RST_HOLD`, default 100: clk cycles `RESET_ASW` stays low after `reset_n` deasserts. Legal range ≥ 1.
- `clk`  in  1: 100 MHz system clock. Single clock domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `startflag`  in  1: single-cycle write request. Ignored while `busy`=1.
- `ASW_Addr`  in  2: A1:A0 pins of the target ADG715.
- `ASW_Channel`  in  3: index of the switch to close. Exactly one switch is closed per write.
- `SDA_ASW_i`  in  1: SDA pad input, used for ACK.
- `SDA_ASW_oe`  out  1: 1 = pull SDA low. 0 = release SDA (pull-up gives 1).
- `SCL_ASW`  out  1: I2C clock, push-pull.
- `RESET_ASW`  out  1: active-low reset to the ADG715s.
- `busy`  out  1: transaction in progress, or reset hold in progress.
- `Stopflag`  out  1: one-cycle pulse when a transaction completes.
- `nack`  out  1: valid only while `Stopflag`=1. Set to 1 if either ACK slot read high.

## Operation
- **Request acceptance.** `startflag` is sampled on rising `clk`. It is accepted only when `busy`=0. On acceptance, `ASW_Addr` and `ASW_Channel` are latched and `busy` rises on the next cycle.
- **Transmitted bytes.**
  - Address byte = {5'b10010, A1, A0, 1'b0} (write). Example: A=2 gives 0x94.
  - Data byte = 8'h01 << channel. Example: channel 5 gives 0x20.
- **FSM states:** IDLE → START → ADDR → ACK1 → DATA → ACK2 → STOP → DONE → IDLE. RSTHOLD is entered only from reset.
- **Bit framing.** Every state except IDLE, DONE and RSTHOLD lasts whole bit-times. One bit-time = 4 quarters q0..q3 of `QTR_CYCLES` each.
  - START (1 bit): q0–q1 SCL=1, SDA released; q2–q3 SCL=1, SDA low.
  - Data/ACK bit: q0 SCL=0 with SDA updated; q1–q2 SCL=1; q3 SCL=0.
  - Bytes are sent MSB first. ADDR and DATA are 8 bits each.
  - In ACK1/ACK2 SDA is released. `SDA_ASW_i` is sampled on the last cycle of q2.
  - STOP (1 bit): q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2–q3 SCL=1, SDA released.
- **NACK handling.** A NACK does not abort the transaction. It sets a sticky `nack_r`, which is cleared on acceptance of the next request. The transaction always runs through to STOP.
- **DONE.** Lasts 1 cycle. `Stopflag`=1 and `nack`=`nack_r`. The FSM then returns to IDLE with `busy`=0.
- **Input synchronisation.** `SDA_ASW_i` passes through a 2-flop synchroniser before use.

## Timing
- **Reset values.** While `reset_n`=0:
  - `SCL_ASW`=1, `SDA_ASW_oe`=0
  - `RESET_ASW`=0, `busy`=1
  - `Stopflag`=0, `nack`=0
  - FSM in RSTHOLD, quarter counter = 0
- **Reset hold.** After deassertion, `RESET_ASW` stays 0 for exactly `RST_HOLD` cycles, then goes to 1. `busy` falls on the same edge and the FSM enters IDLE.
- **Transaction latency.** From the acceptance edge (cycle 0):
  - START through STOP spans 20 bit-times = 80×`QTR_CYCLES` cycles (5040 at default).
  - `Stopflag` is high during cycle 80×`QTR_CYCLES`+1.
  - `busy` is 0 from the following cycle.
- **Back-to-back requests.** The earliest next acceptance is on the cycle `busy`=0, i.e. one cycle after `Stopflag`.
- **Simultaneous `startflag` and `Stopflag`.** The request is dropped, because `busy` is still 1. The upstream stage must re-request.
- **Reset mid-transaction.** Asynchronous abort. All outputs take their reset values immediately. No STOP condition is generated; the ADG715 reset pulse clears the bus state.
- **Quarter counter.** Width is $clog2(`QTR_CYCLES`). It wraps at `QTR_CYCLES`-1, and the quarter index advances on wrap.

## Structure
- **Package `adg715_pkg`:** the FSM state enum, ADG715 address prefix 5'b10010, and default `QTR_CYCLES`/`RST_HOLD`.
- **Sub-module `i2c_qtr_tick`:** parameterised divider that emits a one-cycle tick at every quarter boundary plus the 2-bit quarter index. It is cleared on transaction accept.
- **Top level:** FSM, bit/shift counters, synchroniser and reset-hold counter.

## Test plan
- Power-up with `RST_HOLD`=100: `RESET_ASW` low for exactly 100 cycles after `reset_n` rises; `busy` low on the same cycle `RESET_ASW` rises.
- `ASW_Addr`=2, `ASW_Channel`=5, slave ACKs: SDA bits decode to 0x94 then 0x20 with START and STOP present; `Stopflag` pulses at cycle 5041; `nack`=0.
- `ASW_Addr`=0, `ASW_Channel`=0, then `ASW_Addr`=3, `ASW_Channel`=7 issued one cycle after the first `Stopflag`: bytes 0x90/0x01 then 0x96/0x80.
- SDA held high in ACK2: full transaction completes; `nack`=1 with `Stopflag`; the next ACKed transaction reports `nack`=0.
- `startflag` pulsed mid-DATA and again on the `Stopflag` cycle: both are ignored; exactly one transaction is observed.
- `reset_n` asserted mid-ADDR: on the same edge `SCL_ASW`=1, `SDA_ASW_oe`=0, `RESET_ASW`=0 and `busy`=1; after the 100-cycle reset hold the block accepts a new request normally.
